// File: rtl/insn_queue_pkg.sv
// Shared types and sizing for the fetch-to-decode instruction queue.
// Pure declarations: no logic, no latency, no flow control.
// Used by the queue top, its storage array and the handshake interface.
package insn_queue_pkg;

    localparam int IQ_DEPTH = 4;
    localparam int IQ_PTR_W = 2;
    localparam int IQ_CNT_W = 3;

    typedef logic [29:0]         word_addr_t;
    typedef logic [31:0]         word_data_t;
    typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
    typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

    localparam word_data_t ISA_NOP = 32'h0000_0000;
    localparam iq_cnt_t    IQ_FULL = iq_cnt_t'(IQ_DEPTH);

    typedef struct packed {
        word_addr_t pc;
        word_data_t insn;
    } iq_entry_t;

endpackage

// File: rtl/insn_queue_if.sv
// IF-side push and ID-side head handshake bundle for the instruction queue.
// Wires only: no latency of its own.
// if_stall is the IF backpressure, id_stall the ID backpressure.
interface insn_queue_if;
    import insn_queue_pkg::*;

    word_addr_t if_pc;
    word_data_t if_insn;
    logic       if_en;
    logic       if_stall;
    logic       id_stall;
    logic       flush;
    word_addr_t q_pc;
    word_data_t q_insn;
    logic       q_en;
    iq_cnt_t    q_level;

    modport master (
        output if_pc, if_insn, if_en, id_stall, flush,
        input  if_stall, q_pc, q_insn, q_en, q_level
    );

    modport slave (
        input  if_pc, if_insn, if_en, id_stall, flush,
        output if_stall, q_pc, q_insn, q_en, q_level
    );

endinterface

// File: rtl/insn_queue_mem.sv
// 4 x 62-bit register array holding {pc, insn} queue entries, contents not reset.
// Write lands on the rising edge; read is asynchronous (zero latency).
// No flow control here; the queue controller gates the write enable.
module iq_mem
    import insn_queue_pkg::*;
(
    input  logic      clk,
    input  logic      we,
    input  iq_ptr_t   waddr,
    input  iq_entry_t wdata,
    input  iq_ptr_t   raddr,
    output iq_entry_t rdata
);

    iq_entry_t mem [IQ_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/insn_queue.sv
// 4-entry first-word-fall-through instruction queue between IF and ID.
// Latency: entry pushed at edge N is visible at the head in the following cycle.
// Backpressure: if_stall whenever full (even if ID pops); id_stall freezes the head.
module insn_queue
    import insn_queue_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    insn_queue_if.slave  qif
);

    iq_ptr_t   wr_ptr;
    iq_ptr_t   rd_ptr;
    iq_cnt_t   count;
    iq_entry_t wr_entry;
    iq_entry_t rd_entry;
    logic      full;
    logic      q_vld;
    logic      push;
    logic      pop;

    assign full     = (count == IQ_FULL);
    assign q_vld    = (count != '0);
    assign push     = qif.if_en & ~full & ~qif.flush;
    assign pop      = q_vld & ~qif.id_stall & ~qif.flush;
    assign wr_entry = '{pc: qif.if_pc, insn: qif.if_insn};

    iq_mem u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (qif.flush) begin
            // Flush wins over any push/pop arriving in the same cycle.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stale array contents stay hidden behind q_en while empty.
    assign qif.q_en     = q_vld;
    assign qif.q_pc     = q_vld ? rd_entry.pc   : '0;
    assign qif.q_insn   = q_vld ? rd_entry.insn : ISA_NOP;
    assign qif.if_stall = full;
    assign qif.q_level  = count;

endmodule

// File: doc/insn_queue.md
INSN_QUEUE -- requirements
Module: insn_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_pc  input  30 (WordAddrBus)  PC of the fetched instruction, from the IF/ID register.
REQ-005 if_insn  input  32 (WordDataBus)  fetched instruction.
REQ-006 if_en  input  1  if_pc/if_insn valid this cycle.
REQ-007 id_stall  input  1  ID cannot consume this cycle.
REQ-008 flush  input  1  pipeline flush; discard all queued and incoming entries.
REQ-009 if_stall  output  1  queue full; IF holds its current entry.
REQ-010 q_pc  output  30  head-entry PC to ID.
REQ-011 q_insn  output  32  head-entry instruction to ID.
REQ-012 q_en  output  1  head entry valid.
REQ-013 q_level  output  3  current occupancy, 0..4.

Function
REQ-014 Storage SHALL be IQ_DEPTH=4 entries of {pc[29:0], insn[31:0]}, organised as a circular FIFO with 2-bit write and read pointers and a 3-bit count.
REQ-015 if_stall SHALL be asserted combinationally when count==4, independent of id_stall.
REQ-016 push SHALL be defined as if_en & ~if_stall & ~flush; on push, the entry is written at wr_ptr and wr_ptr increments mod 4.
REQ-017 q_en SHALL equal (count!=0); q_pc/q_insn SHALL be the entry at rd_ptr, read combinationally (first-word fall-through).
REQ-018 When count==0, q_pc SHALL be 0 and q_insn SHALL be `ISA_NOP.
REQ-019 pop SHALL be defined as q_en & ~id_stall & ~flush; on pop, rd_ptr increments mod 4.
REQ-020 Count update SHALL be: +1 on push only, -1 on pop only, unchanged when both occur or neither occurs.
REQ-021 Latency SHALL be 1 cycle: an entry pushed at edge N is presented with q_en=1 in the cycle after edge N; there is no empty-queue bypass.
REQ-022 At full with a simultaneous pop, if_stall SHALL remain 1 that cycle; no push occurs and count goes 4->3.
REQ-023 At empty, pop SHALL be impossible; a push at empty SHALL give count=1 next cycle.
REQ-024 Flush SHALL have priority over all other operations: the next state is count=0 and wr_ptr=rd_ptr=0, and neither the incoming nor the head entry is accepted or consumed that cycle.
REQ-025 Pointer wrap 3->0 SHALL be seamless; FIFO order is preserved across the wrap.
REQ-026 q_level SHALL equal count.
REQ-027 id_stall held high SHALL freeze rd_ptr and hold q_pc/q_insn stable.

Reset
REQ-028 Reset assertion SHALL immediately force count=0, wr_ptr=0 and rd_ptr=0, regardless of clk.
REQ-029 During reset the outputs SHALL be: q_en=0, q_pc=0, q_insn=`ISA_NOP, if_stall=0, q_level=0.
REQ-030 Storage contents SHALL NOT be reset and SHALL NOT be observable while count==0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first push after reset release is the first entry presented.

Structure
REQ-032 IQ_DEPTH (4), IQ_PTR_W (2), IQ_CNT_W (3) and ISA_NOP (32'h0) SHALL be defined in cpu.h.
REQ-033 The register array SHALL be one sub-module, iq_mem: 4x62 bits, one synchronous write port and one asynchronous read port, no reset.
REQ-034 Pointer, count and handshake control SHALL reside in insn_queue itself.

Verification
REQ-035 Reset, then 4 pushes (pc 0x10..0x13) with id_stall=1 -> if_stall=1 and q_level=4 after the 4th edge; q_pc=0x10 throughout.
REQ-036 Full queue with id_stall=0 and if_en=1 for one cycle -> q_level 4->3, no push that cycle; output order is 0x10,0x11,0x12,0x13 with no loss.
REQ-037 Continuous if_en with id_stall=0 for 10 cycles, pc 0x20..0x29 -> q_level stays 1, output sequence 0x20..0x29 in order, one cycle behind input (wrap exercised).
REQ-038 q_level=3 with flush=1 and if_en=1 -> next cycle q_en=0, q_level=0, q_insn=0; the next push appears alone.
REQ-039 Reset asserted asynchronously mid-cycle at q_level=2 -> q_en drops before the next edge; after release the first push appears at the head.
REQ-040 Empty queue with if_en=0 and id_stall toggling -> q_en=0, q_level=0, and no pointer movement.
